// File: rtl/wb_regfile.sv
// wb_regfile: writeback register file with x0 hardwired to zero, same-cycle
// write-to-read bypass and a committed-write counter.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            MUX3_select,
  input  logic            regwrite_enable,
  input  logic [XLEN-1:0] ALU_out,
  input  logic [XLEN-1:0] read_data,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     wb_count
);
  logic [XLEN-1:0] regs_q [NREGS];
  logic [31:0]     wb_count_q, wb_count_d;
  logic            commit, byp1, byp2;

  // Entry 0 is cleared by reset and never written, so x0 reads as zero.
  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] a);
    return (a != 5'd0 && int'(a) < NREGS) ? regs_q[a] : '0;
  endfunction

  always_comb begin
    wb_data    = MUX3_select ? read_data : ALU_out;
    commit     = RESET_N && regwrite_enable && rd != 5'd0 && int'(rd) < NREGS;
    byp1       = commit && rd == rs1;
    byp2       = commit && rd == rs2;
    rs1_data   = !RESET_N ? '0 : byp1 ? wb_data : read_reg(rs1);
    rs2_data   = !RESET_N ? '0 : byp2 ? wb_data : read_reg(rs2);
    wb_count_d = commit ? wb_count_q + 32'd1 : wb_count_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      regs_q     <= '{default: '0};
      wb_count_q <= '0;
    end else begin
      if (commit) regs_q[rd] <= wb_data;
      wb_count_q <= wb_count_d;
    end
  end

  assign wb_count = wb_count_q;
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data width of every register and data port.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning the architectural register count (x0..x31); the index width is 5.
REQ-003 CLK  input  1  is the single clock; all state SHALL update on the rising edge.
REQ-004 RESET_N  input  1  is the reset, asynchronous and active-low.
REQ-005 MUX3_select  input  1  selects the write-back source: 0 = ALU_out, 1 = read_data.
REQ-006 regwrite_enable  input  1  requests a register write this cycle.
REQ-007 ALU_out  input  XLEN  is the ALU result from the writeback pipeline register.
REQ-008 read_data  input  XLEN  is the memory load data from the writeback pipeline register.
REQ-009 rd  input  5  is the destination register index.
REQ-010 rs1, rs2  input  5 each  are the decode-stage source register indices.
REQ-011 rs1_data, rs2_data  output  XLEN each  are the source operand values.
REQ-012 wb_data  output  XLEN  is the selected write-back value, exported for forwarding.
REQ-013 wb_count  output  32  counts committed register writes.

Function
REQ-014 wb_data SHALL equal read_data when MUX3_select=1, and ALU_out otherwise; this path is combinational with zero latency.
REQ-015 A commit SHALL occur on a rising CLK edge when RESET_N=1, regwrite_enable=1 and rd!=0; at that edge the register at index rd SHALL be loaded with wb_data.
REQ-016 Writes with rd=0 SHALL be discarded; x0 SHALL read as 0 at all times.
REQ-017 rs1_data and rs2_data SHALL be combinational reads of the array.
REQ-018 Same-cycle bypass: when regwrite_enable=1, rd!=0 and rd==rs1, rs1_data SHALL equal wb_data rather than the stored value; the identical rule SHALL apply to rs2.
REQ-019 When rs1==rs2, both outputs SHALL be identical, including under bypass.
REQ-020 wb_count SHALL increment by 1 on each commit; a write to x0 SHALL NOT count.
REQ-021 wb_count SHALL wrap from 0xFFFFFFFF to 0x00000000 without a flag.
REQ-022 Back-to-back commits to the same rd SHALL leave the value of the later commit stored.
REQ-023 X or Z on rd, MUX3_select or the data inputs while regwrite_enable=0 SHALL NOT alter any state.

Reset
REQ-024 On RESET_N falling, all registers x1..x31 and wb_count SHALL clear to 0 immediately, without waiting for CLK.
REQ-025 While RESET_N=0, no commit SHALL occur, and rs1_data/rs2_data SHALL read 0.
REQ-026 The bypass SHALL be suppressed while RESET_N=0.
REQ-027 When reset is asserted mid-write (the same cycle as a pending commit), the write SHALL be lost and wb_count SHALL stay 0.
REQ-028 The first commit SHALL be accepted on the first rising edge after RESET_N returns high.

Verification
REQ-029 Reset, then read all indices -> rs1_data=rs2_data=0 and wb_count=0.
REQ-030 Commit rd=5, MUX3_select=0, ALU_out=0x12345678; next cycle rs1=5 -> rs1_data=0x12345678, wb_count=1.
REQ-031 Commit rd=0, ALU_out=0xDEADBEEF; read rs2=0 -> 0, wb_count unchanged.
REQ-032 Set rd=rs1=rs2=7, MUX3_select=1, read_data=0xCAFEF00D, regwrite_enable=1 -> both outputs equal 0xCAFEF00D in the same cycle, before the edge.
REQ-033 Preload wb_count to 0xFFFFFFFF via 2^32-1 commits (or force), then commit once -> wb_count=0.
REQ-034 Fill x1..x31 with distinct values, pulse RESET_N low between edges -> all reads 0 immediately; a commit on the first edge after release succeeds.
